wb_timeout_bridge: RTL and testbench

WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

---
 rtl/wb_timeout_bridge.sv | 147 ++++++++++++++
 tb/tb_wb_timeout_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge: single-outstanding Wishbone bridge between an upstream
// master and a downstream interconnect. It registers each request, watches
// for a downstream acknowledge and, if none arrives within 2^TSIZE-1 wait
// cycles, completes the upstream cycle with ERR_DATA. This keeps the master
// from hanging on an unmapped slave.
//
// Optional feature: define WB_TIMEOUT_IRQ_EN to enable the timeout interrupt
// pulse (irq) and the saturating timeout counter (timeout_cnt). When the
// macro is undefined, both outputs are tied to 0. Timeout completion with
// ERR_DATA still works the same way.
module wb_timeout_bridge #(
  parameter int          TSIZE    = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // upstream (master side)
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  // downstream (toward the interconnect)
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  // timeout reporting
  output logic        irq,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TSIZE-1:0] WAIT_MAX = '1;

  state_t           state;
  logic [TSIZE-1:0] wait_cnt;

`ifdef WB_TIMEOUT_IRQ_EN
  logic       irq_q;
  logic [7:0] tcnt_q;

  assign irq         = irq_q;
  assign timeout_cnt = tcnt_q;
`else
  assign irq         = 1'b0;
  assign timeout_cnt = 8'd0;
`endif

  // Bridge FSM: request capture, downstream wait/timeout, one-cycle upstream response.
  // NOTE: every register here updates with non-blocking assignments. The
  // FSM then reads old-cycle values consistently, and simulation matches
  // the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
`ifdef WB_TIMEOUT_IRQ_EN
      irq_q     <= 1'b0;
      tcnt_q    <= '0;
`endif
    end else begin
`ifdef WB_TIMEOUT_IRQ_EN
      // irq is a single-cycle pulse. It is set only on the edge that
      // enters RESP after a timeout.
      irq_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // wbs_ack_o is low in IDLE, so this check never blocks here.
          // A request offered during RESP is simply seen again next cycle.
          if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
            wbm_we_o  <= wbs_we_i;
            wbm_adr_o <= wbs_adr_i;
            wbm_dat_o <= wbs_dat_i;
            wbm_sel_o <= wbs_sel_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wait_cnt  <= '0;
            state     <= REQ;
          end
        end

        REQ: begin
          if (!wbs_cyc_i) begin
            // Master gave up: drop downstream and return silently.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= IDLE;
          end else if (wbm_ack_i) begin
            // A real acknowledge wins over a timeout on the same cycle.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbs_dat_o <= wbm_dat_i;
            wbs_ack_o <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == WAIT_MAX) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbs_dat_o <= ERR_DATA;
            wbs_ack_o <= 1'b1;
            state     <= RESP;
`ifdef WB_TIMEOUT_IRQ_EN
            irq_q <= 1'b1;
            if (tcnt_q != 8'hFF) begin
              tcnt_q <= tcnt_q + 8'd1;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Testbench for wb_timeout_bridge. The bench plays both the upstream master
// and the downstream slave.
//
// Each transaction is described by a few numbers:
//   - the slave latency (the wait index where ack is given, or none),
//   - an optional abort index,
//   - the slave data.
// From these, the expected trace follows with plain arithmetic:
//   - the first terminating event wins (abort, then ack, then the limit),
//   - downstream stays active for (end index + 1) cycles,
//   - a single RESP cycle follows, unless the transaction was aborted.
// A compare process checks every cycle against these expectations.
module tb_wb_timeout_bridge;

  localparam int          TSIZE    = 8;
  localparam int          LIMIT    = (1 << TSIZE) - 1;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        irq;
  logic [7:0]  timeout_cnt;

  wb_timeout_bridge #(.TSIZE(TSIZE), .ERR_DATA(ERR_DATA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .irq         (irq),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle. The driver sets them just
  // after each rising edge.
  bit          chk_en = 1'b0;
  logic        exp_mcyc, exp_ack, exp_irq, exp_we;
  logic [31:0] exp_adr, exp_mdat, exp_sdat;
  logic [3:0]  exp_sel;
  int          exp_tcnt = 0;

  // Observations of the DUT, used by the hand-computed directed checks.
  int          mon_run = 0, mon_last_run = 0, mon_acks = 0;
  logic [31:0] mon_ack_dat = '0;
  logic        mon_ack_irq = 1'b0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wbm_cyc_o", {31'd0, wbm_cyc_o}, {31'd0, exp_mcyc});
      check("wbm_stb_o", {31'd0, wbm_stb_o}, {31'd0, exp_mcyc});
      check("wbs_ack_o", {31'd0, wbs_ack_o}, {31'd0, exp_ack});
      check("wbs_dat_o", wbs_dat_o, exp_sdat);
      check("irq", {31'd0, irq}, {31'd0, exp_irq});
      check("timeout_cnt", {24'd0, timeout_cnt}, exp_tcnt);
      if (exp_mcyc) begin
        check("wbm_adr_o", wbm_adr_o, exp_adr);
        check("wbm_dat_o", wbm_dat_o, exp_mdat);
        check("wbm_sel_o", {28'd0, wbm_sel_o}, {28'd0, exp_sel});
        check("wbm_we_o", {31'd0, wbm_we_o}, {31'd0, exp_we});
      end
    end
    if (wbm_stb_o === 1'b1) begin
      mon_run++;
    end else if (mon_run != 0) begin
      mon_last_run = mon_run;
      mon_run      = 0;
    end
    if (wbs_ack_o === 1'b1) begin
      mon_acks++;
      mon_ack_dat = wbs_dat_o;
      mon_ack_irq = irq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_mcyc = 1'b0;
    exp_ack  = 1'b0;
    exp_sdat = '0;
    exp_irq  = 1'b0;
  endtask

  task automatic drive_quiet();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'($urandom);
    wbs_adr_i = $urandom;
    wbs_dat_i = $urandom;
    wbs_sel_i = 4'($urandom);
    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom;
  endtask

  // One idle cycle. Sometimes cyc is high without stb; this must not start
  // a request.
  task automatic idle_cycle();
    step();
    exp_idle();
    drive_quiet();
    wbs_cyc_i = 1'($urandom);
  endtask

  // Issue one request.
  //   lat      = wait index at which the slave acks (-1: never)
  //   abort_at = wait index at which the master drops cyc (-1: never)
  //   rst_at   = wait index at which rst_n is driven low (-1: never)
  //   b2b      = keep a fresh request on the bus during the RESP cycle
  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int lat, input int abort_at,
                         input int rst_at, input logic [31:0] sdata, input bit b2b);
    int end_idx;
    int kind;  // 0 = ack, 1 = timeout, 2 = abort, 3 = reset
    end_idx = LIMIT;
    kind    = 1;
    if (lat >= 0 && lat <= LIMIT) begin
      end_idx = lat;
      kind    = 0;
    end
    if (abort_at >= 0 && abort_at <= end_idx) begin
      end_idx = abort_at;
      kind    = 2;
    end
    if (rst_at >= 0 && rst_at <= end_idx) begin
      end_idx = rst_at;
      kind    = 3;
    end
    // Request cycle: the DUT is idle and sees the request at the next edge.
    step();
    exp_idle();
    drive_quiet();
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    // Wait cycles. Upstream inputs are scrambled to prove that the values
    // were captured at the request edge.
    for (int k = 0; k <= end_idx; k++) begin
      step();
      exp_mcyc = 1'b1;
      exp_ack  = 1'b0;
      exp_sdat = '0;
      exp_irq  = 1'b0;
      exp_adr  = adr;
      exp_mdat = dat;
      exp_sel  = sel;
      exp_we   = we;
      drive_quiet();
      wbs_cyc_i = !(kind == 2 && k == end_idx);
      wbs_stb_i = wbs_cyc_i;
      if (kind == 0 && k == end_idx) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = sdata;
      end
      if (kind == 3 && k == end_idx) begin
        rst_n = 1'b0;
      end
    end
    step();
    drive_quiet();
    exp_idle();
    if (kind == 3) begin
      exp_tcnt = 0;
      check("rst_wbm_adr_o", wbm_adr_o, 32'd0);
      check("rst_wbm_dat_o", wbm_dat_o, 32'd0);
      check("rst_wbm_sel_o", {28'd0, wbm_sel_o}, 32'd0);
      check("rst_wbm_we_o", {31'd0, wbm_we_o}, 32'd0);
      rst_n = 1'b1;
    end else if (kind != 2) begin
      exp_ack  = 1'b1;
      exp_sdat = (kind == 0) ? sdata : ERR_DATA;
`ifdef WB_TIMEOUT_IRQ_EN
      if (kind == 1) begin
        exp_irq = 1'b1;
        if (exp_tcnt < 255) exp_tcnt++;
      end
`endif
      if (b2b) begin
        // Offered during the ack cycle: it must not be accepted yet.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0;
    int lat, abt;
    rst_n = 1'b0;
    drive_quiet();
    exp_idle();
    repeat (3) step();
    // Reset state.
    check("reset_wbm_cyc_o", {31'd0, wbm_cyc_o}, 32'd0);
    check("reset_wbs_ack_o", {31'd0, wbs_ack_o}, 32'd0);
    check("reset_wbs_dat_o", wbs_dat_o, 32'd0);
    check("reset_wbm_adr_o", wbm_adr_o, 32'd0);
    check("reset_timeout_cnt", {24'd0, timeout_cnt}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    // Read; the slave acks 3 cycles after stb.
    acks0 = mon_acks;
    run_txn(1'b0, 32'h30010000, 32'h0, 4'hF, 3, -1, -1, 32'h12345678, 1'b0);
    idle_cycle();
    check("rd_stb_cycles", mon_last_run, 4);
    check("rd_ack_count", mon_acks - acks0, 1);
    check("rd_data", mon_ack_dat, 32'h12345678);
    check("rd_irq", {31'd0, mon_ack_irq}, 32'd0);

    // Write with exact downstream fields.
    acks0 = mon_acks;
    run_txn(1'b1, 32'h30020004, 32'hA5A5A5A5, 4'hF, 1, -1, -1, 32'h0, 1'b0);
    idle_cycle();
    check("wr_ack_count", mon_acks - acks0, 1);

    // No slave: timeout after the wait limit.
    acks0 = mon_acks;
    run_txn(1'b0, 32'h30040000, 32'h0, 4'hF, -1, -1, -1, 32'h0, 1'b0);
    idle_cycle();
    check("to_stb_cycles", mon_last_run, 256);
    check("to_data", mon_ack_dat, 32'hDEADBEEF);
    check("to_ack_count", mon_acks - acks0, 1);
`ifdef WB_TIMEOUT_IRQ_EN
    check("to_irq", {31'd0, mon_ack_irq}, 32'd1);
    check("to_count", {24'd0, timeout_cnt}, 32'd1);
`else
    check("to_irq_off", {31'd0, mon_ack_irq}, 32'd0);
`endif

    // Ack on the very cycle the limit is reached: the ack wins.
    run_txn(1'b0, 32'h30040000, 32'h0, 4'h3, LIMIT, -1, -1, 32'hCAFEF00D, 1'b0);
    idle_cycle();
    check("edge_stb_cycles", mon_last_run, 256);
    check("edge_data", mon_ack_dat, 32'hCAFEF00D);
    check("edge_irq", {31'd0, mon_ack_irq}, 32'd0);

    // Abort at wait cycle 10, then reset in the middle of a second request.
    acks0 = mon_acks;
    run_txn(1'b0, 32'h30030000, 32'h0, 4'hF, -1, 10, -1, 32'h0, 1'b0);
    idle_cycle();
    check("abort_stb_cycles", mon_last_run, 11);
    run_txn(1'b1, 32'h30030008, 32'h11112222, 4'hC, -1, -1, 5, 32'h0, 1'b0);
    idle_cycle();
    check("abort_rst_ack_count", mon_acks - acks0, 0);
    // The bridge must be back in IDLE and serve a request normally.
    run_txn(1'b0, 32'h30010010, 32'h0, 4'hF, 2, -1, -1, 32'h0BADF00D, 1'b1);
    idle_cycle();
    check("post_rst_data", mon_ack_dat, 32'h0BADF00D);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int r;
      r   = int'($urandom_range(99));
      lat = int'($urandom_range(6));
      abt = -1;
      if (r < 8) lat = -1;
      else if (r < 12) lat = LIMIT - int'($urandom_range(1));
      if ($urandom_range(99) < 15) abt = int'($urandom_range(6));
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), lat, abt, -1,
              $urandom, 1'($urandom));
      repeat ($urandom_range(2)) idle_cycle();
    end
    idle_cycle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
